// File: rtl/serdes_pkg.sv
// Shared types and defaults for the serializer / pair-detector path.
package serdes_pkg;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   localparam int   DEFAULT_WIDTH    = 8;
   localparam logic DEFAULT_IDLE_BIT = 1'b0;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word holding register so that
// back-to-back words stream with no idle bit between them.
module bit_serializer
   import serdes_pkg::*;
#(
   parameter int   WIDTH     = DEFAULT_WIDTH,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = DEFAULT_IDLE_BIT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_bit,
   output logic             out_valid,
   output logic             word_done,
   output logic             busy
);

   localparam int             CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] shift_reg, shift_next;
   logic [WIDTH-1:0] hold_reg, hold_next;
   logic             hold_full_reg, hold_full_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic             out_bit_reg, out_bit_next;
   logic             out_valid_reg, out_valid_next;
   logic             word_done_reg, word_done_next;
   logic             busy_reg, busy_next;
   logic             accept;
   logic [WIDTH-1:0] shifted;

   function automatic logic first_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   // Reset gating keeps words from being accepted (and lost) during reset.
   assign in_ready = !hold_full_reg && !reset;
   assign accept   = in_valid && in_ready;
   assign shifted  = MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0}
                               : {1'b0, shift_reg[WIDTH-1:1]};

   always_comb begin
      state_next     = state_reg;
      shift_next     = shift_reg;
      hold_next      = hold_reg;
      hold_full_next = hold_full_reg;
      cnt_next       = cnt_reg;
      case (state_reg)
         S_IDLE: begin
            if (accept) begin
               shift_next = in_data;
               cnt_next   = '0;
               state_next = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (cnt_reg == LAST_CNT) begin
               // hold_full implies no accept this edge, so the branches are exclusive
               if (hold_full_reg) begin
                  shift_next     = hold_reg;
                  cnt_next       = '0;
                  hold_full_next = 1'b0;
               end else if (accept) begin
                  shift_next = in_data;
                  cnt_next   = '0;
               end else begin
                  state_next = S_IDLE;
               end
            end else begin
               shift_next = shifted;
               cnt_next   = cnt_reg + 1'b1;
               if (accept) begin
                  hold_next      = in_data;
                  hold_full_next = 1'b1;
               end
            end
         end
         default: state_next = S_IDLE;
      endcase

      out_valid_next = (state_next == S_SHIFT);
      out_bit_next   = out_valid_next ? first_bit(shift_next) : IDLE_BIT;
      word_done_next = out_valid_next && (cnt_next == LAST_CNT);
      busy_next      = out_valid_next || hold_full_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= S_IDLE;
         shift_reg     <= '0;
         hold_reg      <= '0;
         hold_full_reg <= 1'b0;
         cnt_reg       <= '0;
         out_bit_reg   <= IDLE_BIT;
         out_valid_reg <= 1'b0;
         word_done_reg <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         shift_reg     <= shift_next;
         hold_reg      <= hold_next;
         hold_full_reg <= hold_full_next;
         cnt_reg       <= cnt_next;
         out_bit_reg   <= out_bit_next;
         out_valid_reg <= out_valid_next;
         word_done_reg <= word_done_next;
         busy_reg      <= busy_next;
      end
   end

   assign out_bit   = out_bit_reg;
   assign out_valid = out_valid_reg;
   assign word_done = word_done_reg;
   assign busy      = busy_reg;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed and random checks of bit_serializer against a word-queue scoreboard.
module tb_bit_serializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] in_data, l_data;
   logic         in_valid, l_valid;
   logic         in_ready, out_bit, out_valid, word_done, busy;
   logic         l_ready, l_bit, l_out_valid, l_done, l_busy;

   bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .out_bit(out_bit), .out_valid(out_valid),
      .word_done(word_done), .busy(busy)
   );

   bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_lsb (
      .clk(clk), .reset(reset), .in_data(l_data), .in_valid(l_valid),
      .in_ready(l_ready), .out_bit(l_bit), .out_valid(l_out_valid),
      .word_done(l_done), .busy(l_busy)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // sampled outputs
   logic s_bit, s_valid, s_done, s_busy, s_ready;
   logic ls_bit, ls_valid, ls_done, ls_busy, ls_ready;

   // scoreboard state
   logic [W-1:0] expq[$];
   logic [W-1:0] cur;
   int bitcnt = 0, acc_cnt = 0, done_cnt = 0;
   int low_cnt = 0, fall_cnt = 0, run = 0, max_run = 0;
   logic prev_ready = 1'b1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: sample at negedge, update the model, then step past posedge.
   task automatic tick(output bit acc);
      @(negedge clk);
      s_bit = out_bit; s_valid = out_valid; s_done = word_done;
      s_busy = busy; s_ready = in_ready;
      ls_bit = l_bit; ls_valid = l_out_valid; ls_done = l_done;
      ls_busy = l_busy; ls_ready = l_ready;
      if (!s_valid) begin
         check("idle_level", {31'd0, s_bit}, 32'd0);
         check("no_partial_word", bitcnt, 0);
         run = 0;
      end else begin
         check("word_done_align", {31'd0, s_done}, {31'd0, bitcnt == W - 1});
         cur = {cur[W-2:0], s_bit};
         bitcnt++;
         run++;
         if (run > max_run) max_run = run;
         if (bitcnt == W) begin
            bitcnt = 0;
            check("word_expected", {31'd0, expq.size() != 0}, 32'd1);
            if (expq.size() != 0) check("word_data", {24'd0, cur}, {24'd0, expq.pop_front()});
         end
      end
      if (s_done) done_cnt++;
      if (!s_ready) low_cnt++;
      if (prev_ready && !s_ready) fall_cnt++;
      prev_ready = s_ready;
      acc = in_valid && s_ready;
      if (acc) begin
         expq.push_back(in_data);
         acc_cnt++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bit a;
      reset = 1'b1;
      tick(a);
      check("ready_low_in_reset", {31'd0, s_ready}, 32'd0);
      check("lsb_ready_low_in_reset", {31'd0, ls_ready}, 32'd0);
      reset = 1'b0;
      expq.delete();
      bitcnt = 0;
   endtask

   // Present a word until accepted; leave in_valid high when keep is set.
   task automatic send(input logic [W-1:0] w, input bit keep);
      bit a;
      int guard;
      in_valid = 1'b1;
      in_data  = w;
      a = 1'b0;
      guard = 0;
      while (!a && guard < 100) begin
         tick(a);
         guard++;
      end
      check("accept_timeout", {31'd0, a}, 32'd1);
      if (!keep) in_valid = 1'b0;
   endtask

   initial begin
      bit a;
      logic [W-1:0] pat;
      int vcnt, guard, acc_base, done_base;

      reset = 1'b1; in_valid = 1'b0; in_data = '0; l_valid = 1'b0; l_data = '0;
      @(posedge clk); #1;
      do_reset();

      // 1) reset values, then a single MSB-first word
      tick(a);
      check("rst_out_bit", {31'd0, s_bit}, 32'd0);
      check("rst_out_valid", {31'd0, s_valid}, 32'd0);
      check("rst_word_done", {31'd0, s_done}, 32'd0);
      check("rst_busy", {31'd0, s_busy}, 32'd0);
      check("rst_ready", {31'd0, s_ready}, 32'd1);
      check("lsb_rst_out_bit", {31'd0, ls_bit}, 32'd1);
      pat = 8'b1011_0010;
      send(pat, 1'b0);
      for (int i = 0; i < W; i++) begin
         tick(a);
         check("t1_bit", {31'd0, s_bit}, {31'd0, pat[W-1-i]});
         check("t1_valid", {31'd0, s_valid}, 32'd1);
         check("t1_done", {31'd0, s_done}, {31'd0, i == W - 1});
         check("t1_busy", {31'd0, s_busy}, 32'd1);
      end
      tick(a);
      check("t1_after_valid", {31'd0, s_valid}, 32'd0);
      check("t1_after_busy", {31'd0, s_busy}, 32'd0);
      $display("[TB] test1 single word done");

      // 2) two back-to-back words, contiguous output, one in_ready window
      low_cnt = 0; fall_cnt = 0; max_run = 0; prev_ready = 1'b1;
      send(8'hFF, 1'b1);
      send(8'h00, 1'b0);
      repeat (3 * W) tick(a);
      check("t2_contiguous_bits", max_run, 2 * W);
      check("t2_ready_low_cycles", low_cnt, W - 1);
      check("t2_ready_windows", fall_cnt, 1);
      check("t2_queue_empty", expq.size(), 0);
      $display("[TB] test2 back-to-back done");

      // 3) LSB-first instance with idle level 1
      l_valid = 1'b1; l_data = 8'h01;
      tick(a);
      check("t3_ready", {31'd0, ls_ready}, 32'd1);
      l_valid = 1'b0;
      for (int i = 0; i < W; i++) begin
         tick(a);
         check("t3_bit", {31'd0, ls_bit}, {31'd0, i == 0});
         check("t3_valid", {31'd0, ls_valid}, 32'd1);
         check("t3_done", {31'd0, ls_done}, {31'd0, i == W - 1});
      end
      tick(a);
      check("t3_idle_valid", {31'd0, ls_valid}, 32'd0);
      check("t3_idle_bit", {31'd0, ls_bit}, 32'd1);
      check("t3_idle_busy", {31'd0, ls_busy}, 32'd0);
      $display("[TB] test3 lsb-first done");

      // 4) reset mid-word with a word held
      send(8'hAA, 1'b1);
      send(8'h55, 1'b0);
      repeat (3) tick(a);
      reset = 1'b1;
      tick(a);
      check("t4_busy_before", {31'd0, s_busy}, 32'd1);
      check("t4_ready_in_reset", {31'd0, s_ready}, 32'd0);
      reset = 1'b0;
      expq.delete();
      bitcnt = 0;
      tick(a);
      check("t4_valid", {31'd0, s_valid}, 32'd0);
      check("t4_bit", {31'd0, s_bit}, 32'd0);
      check("t4_busy", {31'd0, s_busy}, 32'd0);
      vcnt = 0;
      repeat (2 * W) begin
         tick(a);
         if (s_valid) vcnt++;
      end
      check("t4_held_never_sent", vcnt, 0);
      $display("[TB] test4 reset mid-word done");

      // 5) random valid pattern, 200 words
      acc_base = acc_cnt;
      done_base = done_cnt;
      guard = 0;
      while (acc_cnt - acc_base < 200 && guard < 20000) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_data  = W'($urandom);
         tick(a);
         guard++;
      end
      in_valid = 1'b0;
      repeat (3 * W) tick(a);
      check("t5_accepted_all", {31'd0, acc_cnt - acc_base >= 200}, 32'd1);
      check("t5_done_count", done_cnt - done_base, acc_cnt - acc_base);
      check("t5_queue_empty", expq.size(), 0);
      $display("[TB] test5 random stream: %0d words", acc_cnt - acc_base);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
